// File: rtl/lzc_iter_if.sv
// Handshake bundle for lzc_iter: vector input channel and index-beat output channel.
// LZC_ITER_POPCNT_EN adds the remaining_o field.
interface lzc_iter_if #(
    parameter int WIDTH = 34,
    parameter int CNT_W = $clog2(WIDTH)
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] in_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [CNT_W-1:0] cnt_o;
    logic             last_o;
    logic             empty_o;
`ifdef LZC_ITER_POPCNT_EN
    logic [CNT_W:0]   remaining_o;
`endif

    modport master (
        output in_valid_i, in_i, out_ready_i,
`ifdef LZC_ITER_POPCNT_EN
        input  remaining_o,
`endif
        input  in_ready_o, out_valid_o, cnt_o, last_o, empty_o
    );

    modport slave (
        input  in_valid_i, in_i, out_ready_i,
`ifdef LZC_ITER_POPCNT_EN
        output remaining_o,
`endif
        output in_ready_o, out_valid_o, cnt_o, last_o, empty_o
    );
endinterface

// File: rtl/lzc_iter.sv
// Set-bit iterator: loads a vector, then emits the index of each set bit in priority order,
// one beat per cycle. Optional macro LZC_ITER_POPCNT_EN adds the remaining_o popcount output.
module lzc_iter #(
    parameter int WIDTH = 34,
    parameter int MODE  = 0,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      flush_i,
    lzc_iter_if.slave bus
);
    typedef enum logic {S_IDLE, S_SCAN} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_mask;

    logic [WIDTH-1:0] w_ori;
    logic [WIDTH-1:0] w_ori_next;
    logic [WIDTH-1:0] w_mask_next;
    logic             w_scan;
    logic             w_last;
    logic             w_empty;
    logic             w_in_fire;
    logic             w_out_fire;

    // Leading mode is handled by bit-reversing, so one trailing-zero counter serves both
    function automatic logic [WIDTH-1:0] f_orient(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = (MODE == 0) ? v[i] : v[WIDTH-1-i];
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] f_tzc(input logic [WIDTH-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) c = CNT_W'(i);
        end
        return c;
    endfunction

`ifdef LZC_ITER_POPCNT_EN
    function automatic logic [CNT_W:0] f_popcnt(input logic [WIDTH-1:0] v);
        logic [CNT_W:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + {{CNT_W{1'b0}}, v[i]};
        end
        return n;
    endfunction
`endif

    assign w_scan      = (r_state == S_SCAN);
    assign w_ori       = f_orient(r_mask);
    assign w_ori_next  = w_ori & (w_ori - WIDTH'(1));
    assign w_mask_next = f_orient(w_ori_next);
    assign w_last      = (w_ori_next == '0);
    assign w_empty     = (r_mask == '0);

    assign bus.out_valid_o = w_scan;
    assign bus.cnt_o       = w_scan ? f_tzc(w_ori) : '0;
    assign bus.last_o      = w_scan & w_last;
    assign bus.empty_o     = w_scan & w_empty;
`ifdef LZC_ITER_POPCNT_EN
    assign bus.remaining_o = w_scan ? f_popcnt(r_mask) : '0;
`endif

    // A new vector may replace the final beat of the current one in the same cycle
    assign bus.in_ready_o = !rst_i && !flush_i && (!w_scan || (bus.out_ready_i && w_last));
    assign w_in_fire      = bus.in_valid_i && bus.in_ready_o;
    assign w_out_fire     = w_scan && bus.out_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_mask  <= '0;
        end else if (flush_i) begin
            r_state <= S_IDLE;
            r_mask  <= '0;
        end else if (w_in_fire) begin
            r_state <= S_SCAN;
            r_mask  <= bus.in_i;
        end else if (w_out_fire) begin
            if (w_last) begin
                r_state <= S_IDLE;
                r_mask  <= '0;
            end else begin
                r_mask  <= w_mask_next;
            end
        end
    end
endmodule

// File: tb/tb_lzc_iter.sv
// Bench for lzc_iter: a trailing-mode and a leading-mode instance share all stimulus;
// directed timing cases first, then randomized vectors against a queue scoreboard.
module tb_lzc_iter;
    localparam int WIDTH = 34;
    localparam int CNT_W = $clog2(WIDTH);

    typedef struct {
        int cnt;
        int last;
        int empty;
        int rem;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             out_ready = 1'b0;

    int    checks = 0;
    int    errors = 0;
    beat_t exp0[$];
    beat_t exp1[$];
    bit    sb_en = 1'b0;
    int    rdy_mode = 0;

    always #5 clk = ~clk;

    lzc_iter_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) if0 ();
    lzc_iter_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) if1 ();

    assign if0.in_valid_i  = in_valid;
    assign if0.in_i        = in_data;
    assign if0.out_ready_i = out_ready;
    assign if1.in_valid_i  = in_valid;
    assign if1.in_i        = in_data;
    assign if1.out_ready_i = out_ready;

    lzc_iter #(.WIDTH(WIDTH), .MODE(0), .CNT_W(CNT_W)) dut0 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(if0.slave));
    lzc_iter #(.WIDTH(WIDTH), .MODE(1), .CNT_W(CNT_W)) dut1 (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .bus(if1.slave));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_out(input string t, input int v, input int c0, input int c1,
                           input int l, input int e);
        chk({t, "_valid0"}, int'(if0.out_valid_o), v);
        chk({t, "_valid1"}, int'(if1.out_valid_o), v);
        chk({t, "_cnt0"},   int'(if0.cnt_o), c0);
        chk({t, "_cnt1"},   int'(if1.cnt_o), c1);
        chk({t, "_last0"},  int'(if0.last_o), l);
        chk({t, "_last1"},  int'(if1.last_o), l);
        chk({t, "_empty0"}, int'(if0.empty_o), e);
        chk({t, "_empty1"}, int'(if1.empty_o), e);
    endtask

    // Reference: list set-bit indices, then order and number them per direction
    task automatic model_push(input logic [WIDTH-1:0] v);
        int    idx[$];
        int    k;
        beat_t b;
        for (int i = 0; i < WIDTH; i++) if (v[i]) idx.push_back(i);
        k = idx.size();
        if (k == 0) begin
            b = '{cnt: 0, last: 1, empty: 1, rem: 0};
            exp0.push_back(b);
            exp1.push_back(b);
        end else begin
            for (int j = 0; j < k; j++) begin
                b = '{cnt: idx[j], last: int'(j == k - 1), empty: 0, rem: k - j};
                exp0.push_back(b);
                b = '{cnt: WIDTH - 1 - idx[k-1-j], last: int'(j == k - 1), empty: 0, rem: k - j};
                exp1.push_back(b);
            end
        end
    endtask

    task automatic compare_beat(input int m, input int c, input int l, input int e, input int r);
        beat_t b;
        if ((m == 0 && exp0.size() == 0) || (m == 1 && exp1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL extra_beat_m%0d actual cnt=%0d required no beat", m, c);
            return;
        end
        b = (m == 0) ? exp0[0] : exp1[0];
        chk($sformatf("sb_cnt_m%0d", m), c, b.cnt);
        chk($sformatf("sb_last_m%0d", m), l, b.last);
        chk($sformatf("sb_empty_m%0d", m), e, b.empty);
`ifdef LZC_ITER_POPCNT_EN
        chk($sformatf("sb_rem_m%0d", m), r, b.rem);
`else
        if (r != 0) chk($sformatf("sb_rem_m%0d", m), r, 0);
`endif
    endtask

    bit prev_stall = 1'b0;
    int h_cnt0, h_cnt1, h_last, h_empty;

    always @(negedge clk) begin
        int r0, r1;
        r0 = 0;
        r1 = 0;
`ifdef LZC_ITER_POPCNT_EN
        r0 = int'(if0.remaining_o);
        r1 = int'(if1.remaining_o);
`endif
        if (sb_en) begin
            if (prev_stall) begin
                chk("stall_valid", int'(if0.out_valid_o), 1);
                chk("stall_cnt0", int'(if0.cnt_o), h_cnt0);
                chk("stall_cnt1", int'(if1.cnt_o), h_cnt1);
                chk("stall_last", int'(if0.last_o), h_last);
                chk("stall_empty", int'(if0.empty_o), h_empty);
            end
            if (if0.out_valid_o) begin
                compare_beat(0, int'(if0.cnt_o), int'(if0.last_o), int'(if0.empty_o), r0);
                if (out_ready && exp0.size() > 0) void'(exp0.pop_front());
            end
            if (if1.out_valid_o) begin
                compare_beat(1, int'(if1.cnt_o), int'(if1.last_o), int'(if1.empty_o), r1);
                if (out_ready && exp1.size() > 0) void'(exp1.pop_front());
            end
            prev_stall = if0.out_valid_o && !out_ready;
            h_cnt0  = int'(if0.cnt_o);
            h_cnt1  = int'(if1.cnt_o);
            h_last  = int'(if0.last_o);
            h_empty = int'(if0.empty_o);
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode == 1) out_ready = ~out_ready;
            else if (rdy_mode == 2) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [WIDTH-1:0] v);
        bit acc;
        in_valid = 1'b1;
        in_data  = v;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            acc = in_valid && if0.in_ready_o;
            if (acc) model_push(v);
            tick();
            if (acc) break;
            if (n > 300) begin
                checks++;
                errors++;
                $display("FAIL send_timeout actual=not accepted required=accepted");
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] v;
        int sel, guard;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", int'(if0.in_ready_o), 0);
        exp_out("rst", 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", int'(if0.in_ready_o), 1);
        exp_out("idle", 0, 0, 0, 0, 0);

        // Three-bit vector, both directions
        tick();
        in_valid = 1'b1; in_data = 34'h2_0000_0005; out_ready = 1'b1;
        @(negedge clk);
        chk("A_in_ready", int'(if0.in_ready_o), 1);
        tick();
        in_valid = 1'b0;
        @(negedge clk); exp_out("A1", 1, 0, 0, 0, 0);
        tick();
        @(negedge clk); exp_out("A2", 1, 2, 31, 0, 0);
        tick();
        @(negedge clk); exp_out("A3", 1, 33, 33, 1, 0);
        chk("A3_in_ready", int'(if0.in_ready_o), 1);
        tick();
        @(negedge clk); exp_out("A4", 0, 0, 0, 0, 0);
        chk("A4_in_ready", int'(if0.in_ready_o), 1);

        // Empty vector
        tick();
        in_valid = 1'b1; in_data = '0;
        tick();
        in_valid = 1'b0;
        @(negedge clk); exp_out("B1", 1, 0, 0, 1, 1);
        tick();
        @(negedge clk); exp_out("B2", 0, 0, 0, 0, 0);

        // Back-to-back vectors
        tick();
        in_valid = 1'b1; in_data = 34'h1;
        tick();
        in_data = 34'h8;
        @(negedge clk); exp_out("C1", 1, 0, 33, 1, 0);
        chk("C1_in_ready", int'(if0.in_ready_o), 1);
        tick();
        in_valid = 1'b0;
        @(negedge clk); exp_out("C2", 1, 3, 30, 1, 0);
        tick();
        @(negedge clk); exp_out("C3", 0, 0, 0, 0, 0);

        // Flush on the second beat
        tick();
        in_valid = 1'b1; in_data = 34'h7;
        tick();
        in_valid = 1'b0;
        @(negedge clk); exp_out("D1", 1, 0, 31, 0, 0);
        tick();
        flush = 1'b1;
        @(negedge clk); exp_out("D2", 1, 1, 32, 0, 0);
        chk("D2_in_ready", int'(if0.in_ready_o), 0);
        tick();
        flush = 1'b0;
        @(negedge clk); exp_out("D3", 0, 0, 0, 0, 0);
        tick();
        @(negedge clk); exp_out("D4", 0, 0, 0, 0, 0);
        chk("D4_in_ready", int'(if0.in_ready_o), 1);

        // Asynchronous reset mid-scan
        tick();
        in_valid = 1'b1; in_data = '1;
        tick();
        in_valid = 1'b0;
        @(negedge clk); exp_out("E1", 1, 0, 0, 0, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        exp_out("E2", 0, 0, 0, 0, 0);
        chk("E2_in_ready", int'(if0.in_ready_o), 0);
        tick();
        rst = 1'b0;
        @(negedge clk); exp_out("E3", 0, 0, 0, 0, 0);
        chk("E3_in_ready", int'(if0.in_ready_o), 1);

        // Scoreboarded phase: full vector under toggled ready, then random traffic
        tick();
        sb_en = 1'b1;
        rdy_mode = 1;
        send('1);
        rdy_mode = 2;
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 4);
            case (sel)
                0: v = '0;
                1: v = '1;
                2: v = WIDTH'(1) << $urandom_range(0, WIDTH - 1);
                3: v = WIDTH'({$urandom(), $urandom()});
                default: v = WIDTH'({$urandom(), $urandom()}) & WIDTH'({$urandom(), $urandom()})
                             & WIDTH'({$urandom(), $urandom()});
            endcase
            send(v);
            repeat ($urandom_range(0, 2)) tick();
        end
        guard = 0;
        while ((exp0.size() + exp1.size()) != 0 && guard < 3000) begin
            tick();
            guard++;
        end
        chk("drain_pending", exp0.size() + exp1.size(), 0);
        tick();
        sb_en = 1'b0;
        rdy_mode = 0;
        @(negedge clk);
        exp_out("end", 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
